// File: rtl/router_psum.sv
// router_psum: latches X_dim column psums on a compute_done rising edge and drains them
// one word per cycle into the psum GLB. Define PSUM_ACCUM_EN for read-modify-write accumulation.
module router_psum #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = 3,
    parameter int PSUM_WRITE_ADDR   = 500,
    parameter int NUM_ITER          = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_BITWIDTH-1:0]     pe_out [X_dim],
    input  logic                         compute_done,
    output logic                         write_en_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
    output logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
    output logic                         read_req_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum,
    input  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum,
    output logic                         busy,
    output logic                         store_done,
    output logic                         overrun
);

    // state | meaning
    // IDLE  | waiting for compute_done edge; closes out a finished drain (store_done)
    // READ  | request GLB word base+i (accumulation builds only)
    // WRITE | write buf[i] (plus read-back data) to base+i, advance i

    localparam int IDX_W  = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

`ifdef PSUM_ACCUM_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    localparam state_t ELEM_START = READ;
`else
    typedef enum logic [0:0] {IDLE, WRITE} state_t;
    localparam state_t ELEM_START = WRITE;
`endif

    state_t                       state;
    logic                         cd_q;
    logic [IDX_W-1:0]             idx;
    logic [ITER_W-1:0]            iter;
    logic [DATA_BITWIDTH-1:0]     pbuf [X_dim];
    logic [DATA_BITWIDTH-1:0]     data_q;
    logic [ADDR_BITWIDTH_GLB-1:0] addr_cur;
    logic                         cd_rise;
    logic                         last;

    assign cd_rise  = compute_done & ~cd_q;
    assign last     = (idx == IDX_W'(X_dim - 1));
    assign addr_cur = ADDR_BITWIDTH_GLB'(PSUM_WRITE_ADDR + int'(iter) * X_dim + int'(idx));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cd_q              <= 1'b0;
            idx               <= '0;
            iter              <= '0;
            data_q            <= '0;
            write_en_glb_psum <= 1'b0;
            w_addr_glb_psum   <= '0;
            busy              <= 1'b0;
            store_done        <= 1'b0;
            overrun           <= 1'b0;
            for (int n = 0; n < X_dim; n++) pbuf[n] <= '0;
`ifdef PSUM_ACCUM_EN
            read_req_glb_psum <= 1'b0;
            r_addr_glb_psum   <= '0;
`endif
        end else begin
            cd_q              <= compute_done;
            write_en_glb_psum <= 1'b0;
            store_done        <= 1'b0;
`ifdef PSUM_ACCUM_EN
            read_req_glb_psum <= 1'b0;
`endif
            if (cd_rise && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    // busy still high here means the last write just went out
                    store_done <= busy;
                    busy       <= 1'b0;
                    if (cd_rise) begin
                        for (int n = 0; n < X_dim; n++) pbuf[n] <= pe_out[n];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ELEM_START;
                    end
                end
`ifdef PSUM_ACCUM_EN
                READ: begin
                    read_req_glb_psum <= 1'b1;
                    r_addr_glb_psum   <= addr_cur;
                    state             <= WRITE;
                end
`endif
                WRITE: begin
                    write_en_glb_psum <= 1'b1;
                    w_addr_glb_psum   <= addr_cur;
                    data_q            <= pbuf[idx];
                    idx               <= idx + IDX_W'(1);
                    if (last) begin
                        state <= IDLE;
                        iter  <= (iter == ITER_W'(NUM_ITER - 1)) ? '0 : iter + ITER_W'(1);
                    end else begin
                        state <= ELEM_START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PSUM_ACCUM_EN
    // read data arrives in the write cycle, so the sum is formed combinationally
    assign w_data_glb_psum = write_en_glb_psum ? data_q + r_data_glb_psum : '0;
`else
    logic unused_r_data;
    assign unused_r_data     = ^r_data_glb_psum;
    assign w_data_glb_psum   = data_q;
    assign read_req_glb_psum = 1'b0;
    assign r_addr_glb_psum   = '0;
`endif

endmodule

// File: tb/tb_router_psum.sv
// Bench for router_psum with a behavioural GLB and drain-schedule model.
// Honours PSUM_ACCUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_router_psum;
    localparam int DW = 16, AW = 10, XD = 3, BASE = 500, NI = 3;
`ifdef PSUM_ACCUM_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif

    logic          clk = 1'b0, reset = 1'b0, compute_done = 1'b0;
    logic [DW-1:0] pe_out [XD];
    logic          write_en_glb_psum, read_req_glb_psum, busy, store_done, overrun;
    logic [AW-1:0] w_addr_glb_psum, r_addr_glb_psum;
    logic [DW-1:0] w_data_glb_psum;
    logic [DW-1:0] r_data_glb_psum = '0;
    logic [DW-1:0] next_rdata = '0;

    int ntests = 0, nfail = 0, cyc = 0, model_iter = 0;
    logic [DW-1:0] mem [1024];
    typedef struct { int c; int a; int d; } acc_t;
    acc_t wq[$];
    acc_t rq[$];
    int   sdq[$];
    int   sd_busy_bad = 0, overlap = 0;
    logic pl_valid = 1'b0;
    int   pl_addr = 0;
    logic [DW-1:0] pl_data = '0;

    router_psum dut (
        .clk(clk), .reset(reset), .pe_out(pe_out), .compute_done(compute_done),
        .write_en_glb_psum(write_en_glb_psum), .w_addr_glb_psum(w_addr_glb_psum),
        .w_data_glb_psum(w_data_glb_psum), .read_req_glb_psum(read_req_glb_psum),
        .r_addr_glb_psum(r_addr_glb_psum), .r_data_glb_psum(r_data_glb_psum),
        .busy(busy), .store_done(store_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc             <= cyc + 1;
        r_data_glb_psum <= next_rdata;
    end

    // GLB model and bus monitor; cyc here is the number of the edge that opened this cycle
    always @(negedge clk) begin
        if (pl_valid) mem[pl_addr] = pl_data;
        if (write_en_glb_psum) begin
            wq.push_back('{cyc, int'(w_addr_glb_psum), int'(w_data_glb_psum)});
            mem[w_addr_glb_psum] = w_data_glb_psum;
        end
        if (read_req_glb_psum) rq.push_back('{cyc, int'(r_addr_glb_psum), 0});
        next_rdata = read_req_glb_psum ? mem[r_addr_glb_psum] : DW'($urandom);
        if (store_done) begin
            sdq.push_back(cyc);
            if (busy) sd_busy_bad++;
        end
        if (write_en_glb_psum && read_req_glb_psum) overlap++;
    end

    function automatic int wcyc(int k, int j);
        return (ACC != 0) ? k + 2 + 2 * j : k + 1 + j;
    endfunction
    function automatic int sdcyc(int k);
        return (ACC != 0) ? k + 1 + 2 * XD : k + 1 + XD;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        pl_addr = a; pl_data = d; pl_valid = 1'b1;
        tick();
        pl_valid = 1'b0;
    endtask

    // one-cycle compute_done pulse; returns edge k and the model's expected window/data
    task automatic launch(input logic [DW-1:0] v [XD], output int k,
                          output logic [DW-1:0] ed [XD], output int ea [XD]);
        tick();
        for (int j = 0; j < XD; j++) begin
            pe_out[j] = v[j];
            ea[j] = (BASE + model_iter * XD + j) % 1024;
            ed[j] = (ACC != 0) ? DW'(int'(mem[ea[j]]) + int'(v[j])) : v[j];
        end
        model_iter = (model_iter + 1) % NI;
        compute_done = 1'b1;
        k = cyc + 1;
        tick();
        compute_done = 1'b0;
    endtask

    task automatic wait_sd(input string nm, input int target);
        int t = 0;
        while (sdq.size() < target && t < 200) begin tick(); t++; end
        ntests++;
        if (sdq.size() < target) begin
            nfail++;
            $display("FAIL %s timeout: store_done count %0d, required %0d", nm, sdq.size(), target);
        end
    endtask

    task automatic test_reset();
        int obs [8];
        string nm [8] = '{"write_en", "read_req", "w_addr", "w_data", "r_addr", "busy", "store_done", "overrun"};
        reset = 1'b0;
        repeat (3) tick();
        obs = '{int'(write_en_glb_psum), int'(read_req_glb_psum), int'(w_addr_glb_psum), int'(w_data_glb_psum),
                int'(r_addr_glb_psum), int'(busy), int'(store_done), int'(overrun)};
        for (int n = 0; n < 8; n++) begin
            ntests++;
            if (obs[n] !== 0) begin nfail++; $display("FAIL reset_%s got %0d want 0", nm[n], obs[n]); end
        end
        reset = 1'b1;
        model_iter = 0;
        repeat (2) tick();
        ntests++;
        if (busy !== 1'b0) begin nfail++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int k, w0, s0, b0;
        v = '{16'd10, 16'd20, 16'd30};
        w0 = wq.size(); s0 = sdq.size(); b0 = sd_busy_bad;
        launch(v, k, ed, ea);
        ntests++;
        if (busy !== 1'b1) begin nfail++; $display("FAIL basic_busy got %0b want 1", busy); end
        wait_sd("basic", s0 + 1);
        repeat (2) tick();
        ntests++;
        if (wq.size() - w0 !== XD) begin nfail++; $display("FAIL basic_count got %0d want %0d", wq.size() - w0, XD); end
        for (int j = 0; j < XD && w0 + j < wq.size(); j++) begin
            ntests++;
            if (wq[w0+j].c !== wcyc(k, j) || wq[w0+j].a !== ea[j] || wq[w0+j].d !== int'(ed[j])) begin
                nfail++;
                $display("FAIL basic_wr%0d got c%0d a%0d d%0d want c%0d a%0d d%0d", j, wq[w0+j].c, wq[w0+j].a,
                         wq[w0+j].d, wcyc(k, j), ea[j], ed[j]);
            end
        end
        ntests++;
        if (sdq.size() - s0 !== 1 || sdq[s0] !== sdcyc(k)) begin
            nfail++; $display("FAIL basic_store_done got n%0d c%0d want n1 c%0d", sdq.size() - s0, sdq[s0], sdcyc(k));
        end
        ntests++;
        if (sd_busy_bad !== b0) begin nfail++; $display("FAIL basic_busy_at_done got busy high want low"); end
    endtask

    // three further iterations: windows step by X_dim and wrap after NUM_ITER
    task automatic test_windows();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int k, w0, s0;
        v = '{16'd1, 16'd2, 16'd3};
        for (int it = 0; it < 3; it++) begin
            w0 = wq.size(); s0 = sdq.size();
            launch(v, k, ed, ea);
            wait_sd("windows", s0 + 1);
            for (int j = 0; j < XD; j++) begin
                ntests++;
                if (w0 + j >= wq.size() || wq[w0+j].a !== ea[j] || wq[w0+j].d !== int'(ed[j])) begin
                    nfail++;
                    $display("FAIL windows_it%0d_wr%0d got n%0d want a%0d d%0d", it, j, wq.size() - w0, ea[j], ed[j]);
                end
            end
        end
    endtask

    task automatic test_accum();
`ifdef PSUM_ACCUM_EN
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int k, w0, r0, s0;
        int want [XD] = '{15, 27, 0};
        test_reset();
        preload(500, 16'd5); preload(501, 16'd7); preload(502, 16'hFFFF);
        v = '{16'd10, 16'd20, 16'd1};
        w0 = wq.size(); r0 = rq.size(); s0 = sdq.size();
        launch(v, k, ed, ea);
        wait_sd("accum", s0 + 1);
        for (int j = 0; j < XD; j++) begin
            ntests++;
            if (w0 + j >= wq.size() || wq[w0+j].d !== want[j] || wq[w0+j].a !== 500 + j || wq[w0+j].c !== k + 2 + 2 * j) begin
                nfail++; $display("FAIL accum_wr%0d got n%0d want a%0d d%0d c%0d", j, wq.size() - w0, 500 + j, want[j], k + 2 + 2 * j);
            end
            ntests++;
            if (r0 + j >= rq.size() || rq[r0+j].a !== 500 + j || rq[r0+j].c !== k + 1 + 2 * j) begin
                nfail++; $display("FAIL accum_rd%0d got n%0d want a%0d c%0d", j, rq.size() - r0, 500 + j, k + 1 + 2 * j);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int k, w0, s0;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int j = 0; j < XD; j++) v[j] = DW'($urandom);
            w0 = wq.size(); s0 = sdq.size();
            launch(v, k, ed, ea);
            wait_sd("random", s0 + 1);
            for (int j = 0; j < XD; j++) begin
                ntests++;
                if (w0 + j >= wq.size() || wq[w0+j].c !== wcyc(k, j) || wq[w0+j].a !== ea[j] || wq[w0+j].d !== int'(ed[j])) begin
                    nfail++; $display("FAIL random%0d_wr%0d got n%0d want c%0d a%0d d%0d", r, j, wq.size() - w0, wcyc(k, j), ea[j], ed[j]);
                end
            end
            ntests++;
            if (sdq[s0] !== sdcyc(k)) begin nfail++; $display("FAIL random%0d_store_done got c%0d want c%0d", r, sdq[s0], sdcyc(k)); end
        end
    endtask

    // next edge lands exactly in the store_done cycle of the previous drain
    task automatic test_back_to_back();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed1 [XD], ed2 [XD];
        int ea1 [XD], ea2 [XD];
        int k1, k2, w0, s0;
        for (int j = 0; j < XD; j++) v[j] = DW'($urandom);
        w0 = wq.size(); s0 = sdq.size();
        launch(v, k1, ed1, ea1);
        while (cyc < sdcyc(k1) - 2) tick();
        for (int j = 0; j < XD; j++) v[j] = DW'($urandom);
        launch(v, k2, ed2, ea2);
        wait_sd("b2b", s0 + 2);
        ntests++;
        if (k2 !== sdcyc(k1) || sdq[s0] !== sdcyc(k1) || sdq[s0+1] !== sdcyc(k2)) begin
            nfail++; $display("FAIL b2b_store_done got c%0d c%0d want c%0d c%0d", sdq[s0], sdq[s0+1], sdcyc(k1), sdcyc(k2));
        end
        for (int j = 0; j < 2 * XD; j++) begin
            int ec, a, d;
            ec = (j < XD) ? wcyc(k1, j) : wcyc(k2, j - XD);
            a  = (j < XD) ? ea1[j] : ea2[j - XD];
            d  = (j < XD) ? int'(ed1[j]) : int'(ed2[j - XD]);
            ntests++;
            if (w0 + j >= wq.size() || wq[w0+j].c !== ec || wq[w0+j].a !== a || wq[w0+j].d !== d) begin
                nfail++; $display("FAIL b2b_wr%0d got n%0d want c%0d a%0d d%0d", j, wq.size() - w0, ec, a, d);
            end
        end
        ntests++;
        if (overrun !== 1'b0) begin nfail++; $display("FAIL b2b_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_hold_high();
        int w0, s0, ea0;
        tick();
        for (int j = 0; j < XD; j++) pe_out[j] = DW'($urandom);
        ea0 = (BASE + model_iter * XD) % 1024;
        model_iter = (model_iter + 1) % NI;
        w0 = wq.size(); s0 = sdq.size();
        compute_done = 1'b1;
        repeat (10) tick();
        compute_done = 1'b0;
        repeat (12) tick();
        ntests++;
        if (sdq.size() - s0 !== 1 || wq.size() - w0 !== XD) begin
            nfail++; $display("FAIL hold_count got drains %0d writes %0d want 1 %0d", sdq.size() - s0, wq.size() - w0, XD);
        end
        ntests++;
        if (overrun !== 1'b0) begin nfail++; $display("FAIL hold_overrun got %0b want 0", overrun); end
        ntests++;
        if (wq.size() > w0 && wq[w0].a !== ea0) begin nfail++; $display("FAIL hold_addr got %0d want %0d", wq[w0].a, ea0); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int k, w0, s0;
        for (int j = 0; j < XD; j++) v[j] = DW'($urandom_range(0, 90));
        w0 = wq.size(); s0 = sdq.size();
        launch(v, k, ed, ea);
        tick();
        for (int j = 0; j < XD; j++) pe_out[j] = 16'd99;
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        wait_sd("overrun", s0 + 1);
        repeat (6) tick();
        for (int j = 0; j < XD; j++) begin
            ntests++;
            if (w0 + j >= wq.size() || wq[w0+j].d !== int'(ed[j])) begin
                nfail++; $display("FAIL overrun_wr%0d got n%0d want d%0d", j, wq.size() - w0, ed[j]);
            end
        end
        ntests++;
        if (overrun !== 1'b1 || sdq.size() - s0 !== 1) begin
            nfail++; $display("FAIL overrun_flag got %0b drains %0d want 1 1", overrun, sdq.size() - s0);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] v [XD];
        logic [DW-1:0] ed [XD];
        int ea [XD];
        int obs [6];
        int k, w0, s0, t;
        for (int j = 0; j < XD; j++) v[j] = DW'($urandom);
        w0 = wq.size();
        launch(v, k, ed, ea);
        t = 0;
        while (wq.size() < w0 + 2 && t < 50) begin tick(); t++; end
        ntests++;
        if (wq.size() < w0 + 2) begin nfail++; $display("FAIL rstmid_timeout got %0d writes want 2", wq.size() - w0); end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        obs = '{int'(write_en_glb_psum), int'(read_req_glb_psum), int'(w_addr_glb_psum),
                int'(busy), int'(store_done), int'(overrun)};
        for (int n = 0; n < 6; n++) begin
            ntests++;
            if (obs[n] !== 0) begin nfail++; $display("FAIL rstmid_out%0d got %0d want 0", n, obs[n]); end
        end
        repeat (2) tick();
        ntests++;
        if (wq.size() - w0 !== 2) begin nfail++; $display("FAIL rstmid_writes got %0d want 2", wq.size() - w0); end
        reset = 1'b1;
        model_iter = 0;
        tick();
        w0 = wq.size(); s0 = sdq.size();
        launch(v, k, ed, ea);
        wait_sd("rstmid_after", s0 + 1);
        for (int j = 0; j < XD; j++) begin
            ntests++;
            if (w0 + j >= wq.size() || wq[w0+j].a !== BASE + j || wq[w0+j].c !== wcyc(k, j) || wq[w0+j].d !== int'(ed[j])) begin
                nfail++; $display("FAIL rstmid_after_wr%0d got n%0d want a%0d c%0d d%0d", j, wq.size() - w0, BASE + j, wcyc(k, j), ed[j]);
            end
        end
    endtask

    task automatic test_bus_rules();
        ntests++;
        if (overlap !== 0) begin nfail++; $display("FAIL bus_overlap got %0d want 0", overlap); end
`ifndef PSUM_ACCUM_EN
        ntests++;
        if (rq.size() !== 0 || r_addr_glb_psum !== '0) begin
            nfail++; $display("FAIL bus_no_read got %0d reads addr %0d want 0 0", rq.size(), r_addr_glb_psum);
        end
`endif
    endtask

    initial begin
        for (int j = 0; j < XD; j++) pe_out[j] = '0;
        test_reset();
        test_accum();
        test_basic();
        test_windows();
        test_random();
        test_back_to_back();
        test_hold_high();
        test_overrun();
        test_reset_mid();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/router_psum.md
# router_psum

Downstream stage of the PE cluster. Captures the `X_dim` column partial sums (`pe_out`) when the cluster pulses `compute_done`, then drains them one word per cycle into the psum GLB bank. Each compute iteration goes to a separate address window that advances per iteration. Optionally, each word is added to the value already stored in the GLB (read-modify-write) before it is written back.

## Interface
Parameters:
- `DATA_BITWIDTH`, 16, psum word width.
- `ADDR_BITWIDTH_GLB`, 10, GLB address width.
- `X_dim`, 3, number of PE columns, i.e. psums per iteration.
- `PSUM_WRITE_ADDR`, 500, GLB base address of iteration 0.
- `NUM_ITER`, 3, number of iteration windows before the window index wraps to 0.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pe_out`  in  `DATA_BITWIDTH` × `X_dim` (unpacked)  column psums from the PE cluster.
- `compute_done`  in  1  sampled high for at least one edge when `pe_out` is valid.
- `write_en_glb_psum`  out  1  GLB psum write strobe.
- `w_addr_glb_psum`  out  `ADDR_BITWIDTH_GLB`  GLB psum write address.
- `w_data_glb_psum`  out  `DATA_BITWIDTH`  GLB psum write data.
- `read_req_glb_psum`  out  1  GLB psum read request (used only with `PSUM_ACCUM_EN`).
- `r_addr_glb_psum`  out  `ADDR_BITWIDTH_GLB`  GLB psum read address.
- `r_data_glb_psum`  in  `DATA_BITWIDTH`  GLB read data; valid one cycle after `read_req_glb_psum`.
- `busy`  out  1  high from capture until the drain completes.
- `store_done`  out  1  single-cycle pulse after the last write of an iteration.
- `overrun`  out  1  sticky; set when `compute_done` rises while `busy`.

## Operation
- States: IDLE, WRITE, and, with accumulation compiled in, READ.
- IDLE:
  - On a rising edge of `compute_done` (edge-detected with a registered copy), latch all `X_dim` values of `pe_out` into an internal buffer.
  - Clear the element index `i`.
  - Set `busy`.
  - Go to WRITE, or to READ when accumulation is compiled in.
- READ:
  - Assert `read_req_glb_psum` with `r_addr_glb_psum = base + i`.
  - Go to WRITE.
- WRITE:
  - Assert `write_en_glb_psum` with `w_addr_glb_psum = base + i`.
  - `w_data_glb_psum = buf[i]`, or `buf[i] + r_data_glb_psum` with accumulation.
  - Increment `i`. If `i` was `X_dim-1`, go to IDLE; otherwise go to READ (accumulation) or stay in WRITE.
- Base address: `base = PSUM_WRITE_ADDR + iter*X_dim`.
  - `iter` increments at the end of every drain.
  - `iter` wraps from `NUM_ITER-1` to 0.
- Arithmetic: the add is unsigned modulo 2^`DATA_BITWIDTH`; overflow wraps silently. Addresses are truncated to `ADDR_BITWIDTH_GLB` bits.
- A `compute_done` rising edge while `busy` is ignored; the buffer is not overwritten and `overrun` is set.
- `compute_done` held high does not retrigger the block; a new low-to-high transition is required.

## Timing
- Reset values: all outputs 0, `iter` = 0, `i` = 0, state = IDLE, `overrun` = 0. An asserted reset aborts any drain immediately, and no further GLB strobes are issued.
- Cycle numbering: cycle k is the first clock edge that samples `compute_done` rising.
- Without accumulation:
  - Write of element `i` is active during cycle k+1+i.
  - `store_done` pulses in cycle k+1+`X_dim`.
  - `busy` deasserts in the same cycle.
- With accumulation:
  - Read of element `i` is requested in cycle k+1+2i.
  - Write of element `i` occurs in cycle k+2+2i.
  - `store_done` pulses in cycle k+1+2·`X_dim`.
- The block never asserts `read_req_glb_psum` and `write_en_glb_psum` in the same cycle.
- The earliest accepted next `compute_done` edge is the cycle in which `store_done` pulses.

## Configuration
- `PSUM_ACCUM_EN` defined: READ state present; read-modify-write accumulation into the GLB.
- `PSUM_ACCUM_EN` undefined: READ state removed; plain overwrite; `read_req_glb_psum` and `r_addr_glb_psum` are tied to 0; `r_data_glb_psum` is unused.

## Test plan
- No accumulation, defaults, `pe_out` = {10,20,30}, pulse `compute_done` -> writes (500,10), (501,20), (502,30) in three consecutive cycles; `store_done` pulses once.
- Three more iterations with {1,2,3} -> windows 503–505, then 506–508, then wrap back to 500–502.
- `PSUM_ACCUM_EN`, GLB preloaded 500=5, 501=7, 502=0xFFFF; `pe_out` = {10,20,1} -> writes 15, 27, 0 (wrap); read/write cycles alternate.
- Second `compute_done` edge during a drain with `pe_out` changed to {99,99,99} -> original values still written; `overrun` = 1 and stays 1.
- Reset asserted after the 2nd write -> outputs 0 in the same cycle; after release, the next iteration writes to 500 with `i` = 0.
- `compute_done` held high for 10 cycles -> exactly one drain, no `overrun`.
